// File: rtl/mem_pkg.sv
// Shared definitions for the word-by-word memory copy engine.
package mem_pkg;

    // Controller states; the numeric values are fixed so other blocks can decode them.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_CAP  = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/mem_copy.sv
// Word-by-word memory copy engine: read src[i], write dst[i], ascending, 3 cycles/word.
// Every output is a flop loaded from the current state, so the memory-bus view of a
// phase appears in the cycle after the state register holds that phase.
module mem_copy
    import mem_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] src,
    input  logic [DATA_W-1:0] dst,
    input  logic [DATA_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              mem_addr_en,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_in_en,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_out_en,
    input  logic [DATA_W-1:0] mem_out
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] cur_src_q, cur_src_d;
    logic [DATA_W-1:0] cur_dst_q, cur_dst_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    // Data register doubles as the write-data output; it is nonzero only in the write phase.
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              addr_en_q, addr_en_d;
    logic              in_en_q, in_en_d;
    logic              out_en_q, out_en_d;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state, counters and the next value of every output flop.
    always_comb begin
        state_d   = state_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        rem_d     = rem_q;
        data_d    = '0;
        addr_d    = addr_q;
        busy_d    = (state_q != IDLE);
        done_d    = 1'b0;
        addr_en_d = 1'b0;
        in_en_d   = 1'b0;
        out_en_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // busy_q still shows the trailing DONE cycle; a start seen then is ignored.
                if (start && !busy_q) begin
                    cur_src_d = src;
                    cur_dst_d = dst;
                    rem_d     = len;
                    state_d   = (len == '0) ? DONE : RD_ADDR;
                end
            end
            RD_ADDR: begin
                addr_d    = cur_src_q;
                addr_en_d = 1'b1;
                out_en_d  = 1'b1;
                state_d   = RD_CAP;
            end
            RD_CAP: begin
                out_en_d  = 1'b1;
                state_d   = WR;
            end
            WR: begin
                // This edge closes the bus read-capture phase: mem_out holds the source word.
                data_d    = mem_out;
                addr_d    = cur_dst_q;
                addr_en_d = 1'b1;
                in_en_d   = 1'b1;
                cur_src_d = cur_src_q + DATA_W'(1);
                cur_dst_d = cur_dst_q + DATA_W'(1);
                rem_d     = rem_q - DATA_W'(1);
                state_d   = (rem_q == DATA_W'(1)) ? DONE : RD_ADDR;
            end
            DONE: begin
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output flops; reset clears everything so an aborted copy leaves no strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_src_q <= '0;
            cur_dst_q <= '0;
            rem_q     <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_en_q <= 1'b0;
            in_en_q   <= 1'b0;
            out_en_q  <= 1'b0;
        end else begin
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            rem_q     <= rem_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            addr_en_q <= addr_en_d;
            in_en_q   <= in_en_d;
            out_en_q  <= out_en_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_addr_en = addr_en_q;
    assign mem_addr    = addr_q;
    assign mem_in_en   = in_en_q;
    assign mem_in      = data_q;
    assign mem_out_en  = out_en_q;

endmodule
